// File: rtl/layer5_stream_rx.sv
// Layer-5 receive side of the layer-4 serial feature stream: checks the word
// address sequence and reassembles each DEPTH-word frame into one parallel vector.
module layer5_stream_rx #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 84,
  parameter int AW    = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         din,
  input  logic [AW-1:0]            addr,
  input  logic                     en,
  output logic [0:DEPTH*WIDTH-1]   dout,
  output logic                     valid,
  output logic [7:0]               frame_cnt,
  output logic                     err,
  output logic [7:0]               drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t                          r_state;
  logic [AW-1:0]                   r_exp;
  logic [0:DEPTH-1][WIDTH-1:0]     r_asm;
  logic [0:DEPTH-1][WIDTH-1:0]     r_dout;
  logic                            r_valid;
  logic [7:0]                      r_frame_cnt;
  logic                            r_err;
  logic [7:0]                      r_drop_cnt;

  logic                            w_addr0;
  logic [7:0]                      w_drop_inc;
  logic [0:DEPTH-1][WIDTH-1:0]     w_asm_last;

  assign w_addr0    = (addr == '0);
  assign w_drop_inc = (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;

  // The completing word is merged here so dout includes it on the same edge.
  always_comb begin
    w_asm_last          = r_asm;
    w_asm_last[DEPTH-1] = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_exp       <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_err       <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      if (en) begin
        case (r_state)
          S_IDLE: begin
            if (w_addr0) begin
              r_asm[0] <= din;
              r_exp    <= AW'(1);
              r_state  <= S_RECV;
            end else begin
              r_err      <= 1'b1;
              r_drop_cnt <= w_drop_inc;
              r_state    <= S_DROP;
            end
          end
          S_RECV: begin
            if (addr == r_exp) begin
              r_asm[r_exp] <= din;
              if (addr == LAST) begin
                r_dout      <= w_asm_last;
                r_valid     <= 1'b1;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_exp       <= '0;
                r_state     <= S_IDLE;
              end else begin
                r_exp <= r_exp + AW'(1);
              end
            end else begin
              r_err      <= 1'b1;
              r_drop_cnt <= w_drop_inc;
              // An unexpected word 0 is taken as the start of a fresh frame.
              if (w_addr0) begin
                r_asm[0] <= din;
                r_exp    <= AW'(1);
              end else begin
                r_state <= S_DROP;
              end
            end
          end
          S_DROP: begin
            if (w_addr0) begin
              r_asm[0] <= din;
              r_exp    <= AW'(1);
              r_state  <= S_RECV;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign dout      = r_dout;
  assign valid     = r_valid;
  assign frame_cnt = r_frame_cnt;
  assign err       = r_err;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_layer5_stream_rx.sv
// Bench for layer5_stream_rx: directed and random streams compared every cycle
// against a word-list reference model of the frame reassembly rules.
module tb_layer5_stream_rx;

  localparam int WIDTH = 16;
  localparam int DEPTH = 84;
  localparam int AW    = 7;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [WIDTH-1:0]       din = '0;
  logic [AW-1:0]          addr = '0;
  logic                   en = 1'b0;
  logic [0:DEPTH*WIDTH-1] dout;
  logic                   valid;
  logic [7:0]             frame_cnt;
  logic                   err;
  logic [7:0]             drop_cnt;

  layer5_stream_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr), .en(en),
    .dout(dout), .valid(valid), .frame_cnt(frame_cnt), .err(err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  string cur = "init";

  // Reference model: words accepted so far in the current frame (m_next),
  // and whether sync was lost and we are waiting for a word 0.
  logic [WIDTH-1:0]       m_buf [DEPTH];
  logic [0:DEPTH*WIDTH-1] m_dout = '0;
  int                     m_next = 0;
  bit                     m_lost = 0;
  bit                     m_valid = 0;
  int                     m_fc = 0;
  int                     m_dc = 0;
  bit                     m_err = 0;

  task automatic model_step(input bit r, input bit e, input int a, input logic [WIDTH-1:0] d);
    if (r) begin
      m_dout = '0; m_valid = 0; m_fc = 0; m_err = 0; m_dc = 0; m_next = 0; m_lost = 0;
      return;
    end
    m_valid = 0;
    if (!e) return;
    if (!m_lost && a == m_next) begin
      m_buf[a] = d;
      m_next++;
      if (m_next == DEPTH) begin
        for (int k = 0; k < DEPTH; k++) m_dout[k*WIDTH +: WIDTH] = m_buf[k];
        m_valid = 1;
        m_fc = (m_fc + 1) % 256;
        m_next = 0;
      end
    end else if (a == 0) begin
      if (!m_lost) begin m_err = 1; if (m_dc < 255) m_dc++; end
      m_buf[0] = d;
      m_next = 1;
      m_lost = 0;
    end else begin
      if (!m_lost) begin m_err = 1; if (m_dc < 255) m_dc++; end
      m_lost = 1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s [%s] observed=%0d expected=%0d", tag, cur, obs, expv);
    end
  endtask

  task automatic chk_dout();
    int bad;
    bad = -1;
    for (int k = 0; k < DEPTH; k++)
      if (bad < 0 && dout[k*WIDTH +: WIDTH] !== m_dout[k*WIDTH +: WIDTH]) bad = k;
    checks++;
    assert (dout === m_dout) else begin
      failures++;
      $error("FAIL dout [%s] first bad word %0d observed=%h expected=%h", cur, bad,
             dout[bad*WIDTH +: WIDTH], m_dout[bad*WIDTH +: WIDTH]);
    end
  endtask

  // One clock: drive, let the edge happen, update model, compare just after.
  task automatic step(input bit r, input bit e, input int a, input logic [WIDTH-1:0] d);
    rst = r; en = e; addr = AW'(a); din = d;
    @(posedge clk);
    model_step(r, e, a, d);
    #1;
    if (valid === 1'b1) pulses++;
    chk("valid", int'(valid), int'(m_valid));
    chk("frame_cnt", int'(frame_cnt), m_fc);
    chk("err", int'(err), int'(m_err));
    chk("drop_cnt", int'(drop_cnt), m_dc);
    chk_dout();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
  endtask

  task automatic frame(input logic [WIDTH-1:0] base, input bit gaps);
    for (int k = 0; k < DEPTH; k++) begin
      step(0, 1, k, base + WIDTH'(k));
      if (gaps && (k % 10) == 9) idle(3);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    int p0, t_a, t_b;

    // Reset state
    cur = "reset";
    do_reset();
    chk("rst_dout_w0", int'(dout[0 +: WIDTH]), 0);
    chk("rst_valid", int'(valid), 0);

    // Single clean frame, din = addr+1
    cur = "single";
    pulses = 0;
    frame(16'd1, 0);
    chk("single_valid_now", int'(valid), 1);
    step(0, 0, 0, '0);
    chk("single_valid_low", int'(valid), 0);
    chk("single_pulses", pulses, 1);
    chk("single_w0", int'(dout[0 +: WIDTH]), 1);
    chk("single_w83", int'(dout[83*WIDTH +: WIDTH]), 84);
    chk("single_fc", int'(frame_cnt), 1);
    chk("single_err", int'(err), 0);

    // Same frame with gaps after every 10th word
    cur = "gaps";
    do_reset();
    pulses = 0;
    frame(16'd1, 1);
    idle(2);
    chk("gaps_pulses", pulses, 1);
    chk("gaps_w41", int'(dout[41*WIDTH +: WIDTH]), 42);
    chk("gaps_fc", int'(frame_cnt), 1);

    // Back-to-back frames, negative words preserved
    cur = "b2b";
    do_reset();
    pulses = 0;
    t_a = 0; t_b = 0;
    for (int k = 0; k < 2*DEPTH; k++) begin
      w = (k < DEPTH) ? 16'h1000 + 16'(k) : 16'hF000 + 16'(k - DEPTH);
      step(0, 1, k % DEPTH, w);
      if (valid === 1'b1) begin if (t_a == 0) t_a = k; else t_b = k; end
    end
    chk("b2b_pulses", pulses, 2);
    chk("b2b_spacing", t_b - t_a, DEPTH);
    chk("b2b_w0", int'(dout[0 +: WIDTH]), 32'hF000);
    chk("b2b_w83", int'(dout[83*WIDTH +: WIDTH]), 32'hF053);
    chk("b2b_fc", int'(frame_cnt), 2);

    // Skipped address 40, then clean 0x7FFF frame
    cur = "skip";
    do_reset();
    pulses = 0;
    for (int k = 0; k < DEPTH; k++) if (k != 40) step(0, 1, k, 16'h2000 + 16'(k));
    chk("skip_err", int'(err), 1);
    chk("skip_drop", int'(drop_cnt), 1);
    chk("skip_pulses", pulses, 0);
    for (int k = 0; k < DEPTH; k++) step(0, 1, k, 16'h7FFF);
    chk("skip_fc", int'(frame_cnt), 1);
    chk("skip_w60", int'(dout[60*WIDTH +: WIDTH]), 32'h7FFF);

    // Start at addr 5, restart at word 30, addr 90 injection
    cur = "resync";
    do_reset();
    for (int k = 5; k < 20; k++) step(0, 1, k, 16'h3000 + 16'(k));
    for (int k = 0; k < 30; k++) step(0, 1, k, 16'h4000 + 16'(k));
    frame(16'h5000, 0);
    chk("resync_drop", int'(drop_cnt), 2);
    chk("resync_err", int'(err), 1);
    chk("resync_fc", int'(frame_cnt), 1);
    chk("resync_w29", int'(dout[29*WIDTH +: WIDTH]), 32'h501D);
    for (int k = 0; k < 10; k++) step(0, 1, k, 16'h6000);
    step(0, 1, 90, 16'h6666);
    step(0, 1, 10, 16'h6000);
    chk("addr90_drop", int'(drop_cnt), 3);
    frame(16'h0100, 0);
    chk("addr90_fc", int'(frame_cnt), 2);

    // Reset mid-frame with en high
    cur = "midrst";
    do_reset();
    frame(16'h0A00, 0);
    step(0, 1, 0, 16'h1);
    step(0, 1, 7, 16'h1);
    for (int k = 0; k < 50; k++) step(0, 1, k, 16'h0B00);
    step(1, 1, 50, 16'h0B32);
    chk("midrst_fc", int'(frame_cnt), 0);
    chk("midrst_drop", int'(drop_cnt), 0);
    chk("midrst_err", int'(err), 0);
    for (int k = 51; k < DEPTH; k++) step(0, 1, k, 16'h0B00);
    frame(16'h0C00, 0);
    chk("midrst_fc2", int'(frame_cnt), 1);
    chk("midrst_drop2", int'(drop_cnt), 1);

    // Random streams: mostly in-order with random gaps and corruptions
    cur = "random";
    do_reset();
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < DEPTH; k++) begin
        int a;
        a = k;
        case ($urandom_range(0, 59))
          0: a = $urandom_range(0, 127);
          1: a = 0;
          2: a = k + 1;
          default: ;
        endcase
        step(0, 1, a, WIDTH'($urandom));
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
    end

    // drop_cnt saturation
    cur = "sat";
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 0, 16'h1);
      step(0, 1, 5, 16'h1);
    end
    chk("sat_drop", int'(drop_cnt), 255);

    // frame_cnt wrap
    cur = "wrap";
    do_reset();
    p0 = 0;
    for (int f = 0; f < 257; f++) begin
      for (int k = 0; k < DEPTH; k++) step(0, 1, k, WIDTH'($urandom));
      if (f == 255) p0 = int'(frame_cnt);
    end
    chk("wrap_zero", p0, 0);
    chk("wrap_one", int'(frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer5_stream_rx.md
# layer5_stream_rx

Receiving end of the 84-word serial feature stream emitted by the layer-4 ping-pong buffer (16-bit signed word, 7-bit word address, enable strobe). It checks the address sequence, reassembles each 84-word frame into one 1344-bit parallel vector, and presents it to layer 5 with a one-cycle valid pulse. Malformed frames are dropped and flagged; the output vector always holds the last complete, in-order frame.

## Interface
- WIDTH, 16, bits per word
- DEPTH, 84, words per frame
- AW, 7, address width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- din  in  WIDTH  signed word from the upstream stream
- addr  in  AW  word index of din within its frame
- en  in  1  din/addr valid this cycle
- dout  out  [0:DEPTH*WIDTH-1]  assembled frame; word k at bits [k*WIDTH : k*WIDTH+WIDTH-1] (word 0 in MSB-side bits 0..15)
- valid  out  1  one-cycle pulse: dout just updated with a new frame
- frame_cnt  out  8  complete frames delivered, wraps 255->0
- err  out  1  sticky: any sequence violation seen since reset
- drop_cnt  out  8  frames discarded, saturates at 255

## Operation
- Assembly register (DEPTH words) separate from dout; dout changes only on frame completion.
- Expected-address counter exp (0..DEPTH-1).
- States: IDLE (exp=0, nothing captured), RECV (mid-frame), DROP (discarding until resync).
- en low in any state: no change (gaps of any length allowed, no timeout).
- IDLE, en, addr==0: capture word 0, exp=1, -> RECV.
- IDLE, en, addr!=0: err=1, drop_cnt+1, -> DROP.
- RECV, en, addr==exp: capture word at addr, exp+1; if addr==DEPTH-1: copy assembly (including this word) to dout, pulse valid, frame_cnt+1, exp=0, -> IDLE.
- RECV, en, addr!=exp and addr==0: err=1, drop_cnt+1, abandon partial frame, capture word 0 as start of new frame, exp=1, stay RECV.
- RECV, en, addr!=exp and addr!=0: err=1, drop_cnt+1, -> DROP.
- DROP, en, addr==0: capture word 0, exp=1, -> RECV; any other addr ignored (no further drop_cnt increment).
- addr>=DEPTH is always a mismatch (never written).
- Data stored bit-exact; no sign or width conversion.

## Timing
- Capture: word written to assembly on the edge where en=1.
- Latency: last word (addr=DEPTH-1) sampled at edge N -> dout and valid=1 after edge N; valid low after edge N+1.
- Back-to-back frames: word 0 of next frame may arrive the cycle after last word; accepted with no bubble; throughput 1 word/cycle.
- Final word captured and new-frame word 0 never coincide (same cycle is one addr).
- Reset: dout=0, valid=0, frame_cnt=0, err=0, drop_cnt=0, exp=0, state IDLE, assembly contents don't-care.
- Reset mid-frame: partial frame discarded, not counted in drop_cnt; dout cleared to 0; rst has priority over en in the same cycle.
- frame_cnt 255 + 1 -> 0; drop_cnt holds at 255.

## Test plan
- Reset then one frame, en continuous, din=addr+1 for addr 0..83 -> valid single pulse one cycle after addr 83; dout word k = k+1; frame_cnt=1; err=0.
- Same frame with en deasserted 3 cycles after every 10th word -> identical dout, valid once, frame_cnt=1.
- Two frames back-to-back (frame A din=0x1000+k, frame B din=0xF000+k) -> two valid pulses 84 cycles apart; dout=B after second; negative words 0xF000.. preserved bit-exact.
- Frame with addr 40 skipped (39 then 41) -> err=1, drop_cnt=1, no valid; following clean frame with din=0x7FFF -> valid, all words 0x7FFF, frame_cnt=1.
- Stream starting at addr 5, then addr 0 restart mid-frame at word 30 of a new frame -> drop_cnt=2, err=1, next complete frame delivered correctly; addr 90 injected -> treated as mismatch.
- rst asserted at word 50 of a frame with en=1 -> all outputs 0 next cycle; subsequent clean frame -> valid, frame_cnt=1, drop_cnt=0.
